// File: rtl/uart_word_rx.sv
// uart_word_rx: receives the 32-bit word frames sent by the host-side UART
// transmitter on the DVS2SpiNN link. Each frame is one low start bit, then
// 32 data bits LSB first, then a high stop bit. The line is oversampled 16x.
// An oversample tick comes from a clock divider.
//
// Ports:
//   clk          master clock, rising edge
//   rst          synchronous reset, active-low
//   rx           serial line, asynchronous, idle high
//   rx_word      received word, held stable while word_valid is high
//   word_valid   rx_word holds a word the consumer has not yet taken
//   word_ready   consumer takes the word on an edge where valid && ready
//   is_receiving high in every state except IDLE
//   frame_error  one-cycle pulse when the stop bit is sampled low
//   overrun      one-cycle pulse when a good frame is dropped because the
//                previous word is still unconsumed
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s to go low
// START     | start edge seen, confirming the start bit at mid-bit
// DATA      | sampling the 32 data bits at mid-bit, LSB first
// STOP      | waiting for mid stop bit, then deliver / overrun / error
// WAIT_HIGH | stop bit was low; hold off until the line returns high

module uart_word_rx #(
  parameter int CLOCK_DIVIDE = 1085,
  parameter int WORD_BITS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] rx_word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        is_receiving,
  output logic        frame_error,
  output logic        overrun
);

  localparam logic [10:0]      DIV_RELOAD = 11'(CLOCK_DIVIDE - 1);
  localparam int               IDX_W      = $clog2(WORD_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORD_BITS - 1);
  // tcnt value on the tick that lands in the middle of a bit
  localparam logic [3:0]       MID_TICK   = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             rx_meta;
  logic             rx_s;
  logic [10:0]      div_cnt;
  logic [3:0]       tcnt;
  logic [IDX_W-1:0] bit_idx;
  logic [31:0]      shreg;

  logic             tick;
  logic             sample;
  logic             start_det;
  logic             clr_idx;
  logic             shift_en;
  logic             stop_ok;
  logic             stop_bad;
  logic             accept;
  logic             load_word;
  logic             drop_word;

  assign tick   = (div_cnt == 11'd0);
  // Tick counting runs free modulo 16 after the start edge. So every
  // mid-bit sample point is the tick on which tcnt still reads 7.
  assign sample = tick && (tcnt == MID_TICK);

  assign accept    = word_valid && word_ready;
  // If the consumer takes the old word on the same edge, the new word
  // replaces it and no overrun is raised.
  assign load_word = stop_ok && (!word_valid || word_ready);
  assign drop_word = stop_ok && word_valid && !word_ready;

  assign is_receiving = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    clr_idx   = 1'b0;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          start_det = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (sample) begin
          if (!rx_s) begin
            clr_idx   = 1'b1;
            state_nxt = S_DATA;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_IDX) begin
            state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit of margin.
        // That is enough to catch a start bit that follows immediately.
        if (sample) begin
          if (rx_s) begin
            stop_ok   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= S_IDLE;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      state   <= state_nxt;
    end
  end

  // Reloading the divider on the start edge aligns the tick phase to the
  // edge. Mid-bit sampling then depends only on the tick count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= DIV_RELOAD;
      tcnt    <= 4'd0;
    end else begin
      if (start_det || tick) begin
        div_cnt <= DIV_RELOAD;
      end else begin
        div_cnt <= div_cnt - 11'd1;
      end
      if (start_det) begin
        tcnt <= 4'd0;
      end else if (tick) begin
        tcnt <= tcnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_idx <= '0;
      shreg   <= 32'd0;
    end else begin
      if (clr_idx) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
      end
      // LSB arrives first, so each new bit enters at the top.
      // After 32 shifts, bit 0 sits in shreg[0].
      if (shift_en) begin
        shreg <= {rx_s, shreg[31:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_word     <= 32'd0;
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (load_word) begin
        rx_word    <= shreg;
        word_valid <= 1'b1;
      end else if (accept) begin
        word_valid <= 1'b0;
      end
      frame_error <= stop_bad;
      overrun     <= drop_word;
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Testbench for uart_word_rx with CLOCK_DIVIDE=4, so one bit is 64 clk.
// Words expected at the output are queued when their frame is sent. They
// are popped and compared when the consumer accepts them.

module tb_uart_word_rx;

  localparam int CD  = 4;
  localparam int BIT = 16 * CD;
  // Cycles from driving the start edge to the first cycle word_valid is high.
  // 2 synchronizer cycles, 1 detection cycle, then (8+16*32+16)*CD.
  localparam int LAT = 3 + (8 + 16 * 32 + 16) * CD;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [31:0] rx_word;
  logic        word_valid;
  logic        word_ready;
  logic        is_receiving;
  logic        frame_error;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_start  = 0;
  int rise_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int busy_cnt = 0;
  int valid_cnt = 0;
  int words_seen = 0;
  logic valid_q = 1'b0;
  logic [31:0] exp_q[$];

  int s_ferr, s_ovr, s_busy, s_valid, s_words;

  uart_word_rx #(.CLOCK_DIVIDE(CD), .WORD_BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_word      (rx_word),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .is_receiving (is_receiving),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor runs just after each falling edge. It sees the inputs that the
  // next rising edge will act on.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (frame_error) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (is_receiving) busy_cnt++;
      if (word_valid) valid_cnt++;
      if (word_valid && !valid_q) rise_cyc = cyc;
      valid_q = word_valid;
      if (word_valid && word_ready) begin
        words_seen++;
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_word observed=0x%08h expected=none", rx_word);
        end
        if (exp_q.size() != 0) chk("rx_word", rx_word, exp_q.pop_front());
      end
    end else begin
      valid_q = 1'b0;
    end
  end

  task automatic send_frame(input logic [31:0] w, input logic stop_lvl);
    @(negedge clk);
    rx = 1'b0;
    t_start = cyc;
    repeat (BIT - 1) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rx = w[i];
      repeat (BIT - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = stop_lvl;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic snap();
    s_ferr  = ferr_cnt;
    s_ovr   = ovr_cnt;
    s_busy  = busy_cnt;
    s_valid = valid_cnt;
    s_words = words_seen;
  endtask

  initial begin
    logic [31:0] abort_w;
    rst = 1'b0;
    rx = 1'b1;
    word_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_word_valid", 32'(word_valid), 32'd0);
    chk("reset_rx_word", rx_word, 32'd0);
    chk("reset_frame_error", 32'(frame_error), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_is_receiving", 32'(is_receiving), 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Plain frame with the consumer ready
    snap();
    exp_q.push_back(32'hDEADBEEF);
    send_frame(32'hDEADBEEF, 1'b1);
    repeat (20) @(negedge clk);
    chk("t1_words", 32'(words_seen - s_words), 32'd1);
    chk("t1_valid_cycles", 32'(valid_cnt - s_valid), 32'd1);
    chk("t1_ferr", 32'(ferr_cnt - s_ferr), 32'd0);
    chk("t1_ovr", 32'(ovr_cnt - s_ovr), 32'd0);
    chk("t1_latency_ok", 32'((rise_cyc - t_start >= LAT - 1) && (rise_cyc - t_start <= LAT + 1)), 32'd1);

    // Start glitch of 20 clk
    snap();
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("t2_busy_window_ok", 32'((busy_cnt - s_busy >= 30) && (busy_cnt - s_busy <= 36)), 32'd1);
    chk("t2_is_receiving", 32'(is_receiving), 32'd0);
    chk("t2_words", 32'(words_seen - s_words), 32'd0);
    chk("t2_ferr", 32'(ferr_cnt - s_ferr), 32'd0);

    // Low stop bit, then a good frame
    snap();
    send_frame(32'h12345678, 1'b0);
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_ferr_pulse", 32'(ferr_cnt - s_ferr), 32'd1);
    chk("t3_words", 32'(words_seen - s_words), 32'd0);
    chk("t3_word_valid", 32'(word_valid), 32'd0);
    exp_q.push_back(32'h00000001);
    send_frame(32'h00000001, 1'b1);
    repeat (20) @(negedge clk);
    chk("t3_next_words", 32'(words_seen - s_words), 32'd1);
    chk("t3_next_ferr", 32'(ferr_cnt - s_ferr), 32'd1);

    // Overrun: two back-to-back frames, consumer stalled
    snap();
    word_ready = 1'b0;
    exp_q.push_back(32'hAAAAAAAA);
    send_frame(32'hAAAAAAAA, 1'b1);
    send_frame(32'h55555555, 1'b1);
    repeat (20) @(negedge clk);
    chk("t4_ovr_pulse", 32'(ovr_cnt - s_ovr), 32'd1);
    chk("t4_word_valid", 32'(word_valid), 32'd1);
    chk("t4_rx_word_kept", rx_word, 32'hAAAAAAAA);
    chk("t4_ferr", 32'(ferr_cnt - s_ferr), 32'd0);
    @(negedge clk);
    word_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_valid_cleared", 32'(word_valid), 32'd0);
    chk("t4_words", 32'(words_seen - s_words), 32'd1);

    // Reset at bit 10 of a frame
    snap();
    abort_w = 32'hCAFEBABE;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT - 1) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = abort_w[i];
      repeat (BIT - 1) @(negedge clk);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_reset_idle", 32'(is_receiving), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_ferr", 32'(ferr_cnt - s_ferr), 32'd0);
    chk("t5_ovr", 32'(ovr_cnt - s_ovr), 32'd0);
    chk("t5_word_valid", 32'(word_valid), 32'd0);
    exp_q.push_back(32'hFFFF0000);
    send_frame(32'hFFFF0000, 1'b1);
    repeat (20) @(negedge clk);
    chk("t5_words", 32'(words_seen - s_words), 32'd1);

    // New word completes on the same edge the old one is accepted
    word_ready = 1'b0;
    exp_q.push_back(32'h0BADF00D);
    send_frame(32'h0BADF00D, 1'b1);
    repeat (20) @(negedge clk);
    chk("t6_old_valid", 32'(word_valid), 32'd1);
    snap();
    fork
      send_frame(32'h600DCAFE, 1'b1);
      begin
        @(negedge clk);
        repeat (LAT - 1) @(negedge clk);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    chk("t6_valid_held", 32'(word_valid), 32'd1);
    chk("t6_new_word", rx_word, 32'h600DCAFE);
    chk("t6_ovr", 32'(ovr_cnt - s_ovr), 32'd0);
    chk("t6_old_taken", 32'(words_seen - s_words), 32'd1);
    exp_q.push_back(32'h600DCAFE);
    word_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_valid_cleared", 32'(word_valid), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_rx.md
Name: uart_word_rx

Overview:
- Serial receiver for the 32-bit word frames produced by the team's UART transmitter: 1 start bit (low), 32 data bits LSB first, stop level high.
- Sits on the host/serial side of the DVS2SpiNN link. Recovers each word using 16x oversampling, derived from a clock-divider tick.
- Presents each word on a valid/ready output port, with frame-error and overrun flags.

Parameters:
- CLOCK_DIVIDE, 1085: clk cycles per oversample tick. One bit period = 16 ticks = 16*CLOCK_DIVIDE clk. Legal range 2..2047 (11-bit counter).
- WORD_BITS, 32: data bits per frame. Fixed at 32 for this link; other values are not required.

Ports:
- clk  in  1  master clock, rising edge
- rst  in  1  synchronous reset, active-low; rst==0 at a clk edge resets the block
- rx  in  1  serial line, asynchronous, idle high
- rx_word  out  32  received word; stable while word_valid==1
- word_valid  out  1  high while rx_word holds an unconsumed word
- word_ready  in  1  consumer accepts the word on a clk edge where word_valid&&word_ready
- is_receiving  out  1  high in any state other than IDLE
- frame_error  out  1  one-cycle pulse: start glitch rejected is NOT an error; stop bit sampled low IS an error
- overrun  out  1  one-cycle pulse: a good frame completed while word_valid was still high

Behaviour:
- Input sync: rx passes through a 2-FF synchronizer (rx_s) before any use. Both flops reset to 1.
- Tick: an 11-bit divider counts CLOCK_DIVIDE-1 down to 0, producing tick for 1 clk at 0, then reloads.
  - The divider reloads to CLOCK_DIVIDE-1 on the start-edge detection cycle, so phase is aligned to the edge.
  - A 4-bit tick counter, tcnt, counts ticks within the current bit.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rx_s==0, reload divider, clear tcnt, go to START.
- START: on the 8th tick (mid start bit), sample rx_s.
  - rx_s==0: clear the bit index, go to DATA.
  - rx_s==1: glitch; go to IDLE with no flags.
- DATA: sample rx_s every 16 ticks (mid-bit) and shift it in at the MSB: shreg <= {rx_s, shreg[31:1]}.
  - After the 32nd sample, go to STOP. Bit 0 is received first and lands in rx_word[0].
- STOP: 16 ticks after the last data sample, sample rx_s.
  - rx_s==1, word_valid==0: load rx_word from shreg, set word_valid, go to IDLE.
  - rx_s==1, word_valid==1: keep the old word, pulse overrun, drop the new word, go to IDLE.
  - rx_s==0: pulse frame_error, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. Ensures a stuck-low line is not re-taken as a start bit.
- Latency: word_valid rises (8+16*32+16)*CLOCK_DIVIDE clk (±1) after the start edge reaches rx_s. The 2-cycle synchronizer delay precedes this.
- Handshake:
  - word_valid clears on the edge where word_valid&&word_ready.
  - If a new word loads on that same edge (accept and STOP-complete coincide), the new word wins: word_valid stays 1, rx_word takes the new value, and no overrun is flagged.
- Back-to-back: return to IDLE occurs at mid stop bit, so a start bit that immediately follows the stop interval is caught.
- Reset values: word_valid=0, rx_word=0, frame_error=0, overrun=0, is_receiving=0, state=IDLE, shreg=0, divider=CLOCK_DIVIDE-1, tcnt=0.
- Reset mid-frame aborts the frame without any flag. After reset release, a line that is still low is treated as a new start edge.

Test Plan (CLOCK_DIVIDE=4, so 1 bit = 64 clk):
- Drive frame 0xDEADBEEF (start, 32 bits LSB first, stop high) with word_ready=1 -> word_valid pulses 1 cycle with rx_word=0xDEADBEEF; frame_error=0, overrun=0.
- Low glitch of 20 clk on an idle line -> is_receiving high for ~34 clk then 0; no word_valid, no frame_error.
- Frame 0x12345678 with the stop bit held low, then line high -> frame_error 1-cycle pulse, no word_valid. Next good frame 0x00000001 is received correctly.
- word_ready=0; send 0xAAAAAAAA then 0x55555555 back to back -> rx_word stays 0xAAAAAAAA, overrun pulses once. Raising word_ready then clears word_valid.
- Assert rst=0 at bit 10 of a frame, release, then send 0xFFFF0000 -> no flags from the aborted frame; rx_word=0xFFFF0000 is received.
- Word completes on the same edge as an accept of the previous word -> word_valid stays 1 with the new value; overrun=0.
